// File: rtl/sigma_pkg.sv
// Shared SigmaCore decode definitions: opcodes, immediate formats, decode entry.
package sigma_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned OPC_W      = 7;
  localparam int unsigned IMM_TYPE_W = 3;

  localparam logic [OPC_W-1:0] OPC_LOAD     = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [OPC_W-1:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_JALR     = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [OPC_W-1:0] OPC_STORE    = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI      = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL      = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_OP       = 7'b0110011;

  localparam logic [IMM_TYPE_W-1:0] IMM_TYPE_NONE = 3'd0;
  localparam logic [IMM_TYPE_W-1:0] IMM_TYPE_I    = 3'd1;
  localparam logic [IMM_TYPE_W-1:0] IMM_TYPE_S    = 3'd2;
  localparam logic [IMM_TYPE_W-1:0] IMM_TYPE_B    = 3'd3;
  localparam logic [IMM_TYPE_W-1:0] IMM_TYPE_U    = 3'd4;
  localparam logic [IMM_TYPE_W-1:0] IMM_TYPE_J    = 3'd5;

  typedef struct packed {
    logic [XLEN-1:0]       instr;
    logic [IMM_TYPE_W-1:0] imm_type;
    logic [XLEN-1:0]       imm;
    logic                  illegal;
  } dec_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_t;

  // Opcode to {illegal, imm_type}; unknown opcodes map to NONE and flag illegal.
  function automatic logic [IMM_TYPE_W:0] classify(input logic [OPC_W-1:0] opc);
    logic [IMM_TYPE_W:0] res;
    res = {1'b1, IMM_TYPE_NONE};
    case (opc)
      OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM,
      OPC_JALR, OPC_SYSTEM:      res = {1'b0, IMM_TYPE_I};
      OPC_STORE:                 res = {1'b0, IMM_TYPE_S};
      OPC_BRANCH:                res = {1'b0, IMM_TYPE_B};
      OPC_LUI, OPC_AUIPC:        res = {1'b0, IMM_TYPE_U};
      OPC_JAL:                   res = {1'b0, IMM_TYPE_J};
      OPC_OP:                    res = {1'b0, IMM_TYPE_NONE};
      default:                   res = {1'b1, IMM_TYPE_NONE};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sign_extender.sv
// Combinational RV32I immediate extraction and sign extension.
module sign_extender
  import sigma_pkg::*;
(
  input  logic [31:0] instruction_in,
  input  logic [2:0]  imm_type_in,
  output logic [31:0] imm_extended_out
);

  logic [31:0] i;
  logic        unused_opc;

  assign i          = instruction_in;
  assign unused_opc = ^instruction_in[6:0];

  // Reassemble the immediate bits for the selected format.
  always_comb begin
    imm_extended_out = 32'd0;
    case (imm_type_in)
      IMM_TYPE_I: imm_extended_out = {{20{i[31]}}, i[31:20]};
      IMM_TYPE_S: imm_extended_out = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_TYPE_B: imm_extended_out = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_TYPE_U: imm_extended_out = {i[31:12], 12'd0};
      IMM_TYPE_J: imm_extended_out = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:    imm_extended_out = 32'd0;
    endcase
  end

endmodule

// File: rtl/imm_decode_ctrl.sv
// Immediate-decode stage: classify, extend, and buffer in a two-entry skid buffer.
module imm_decode_ctrl
  import sigma_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             instr_valid_in,
  input  logic [31:0]      instr_in,
  output logic             instr_ready_out,
  input  logic             flush_in,
  output logic             dec_valid_out,
  input  logic             dec_ready_in,
  output logic [31:0]      dec_instr_out,
  output logic [2:0]       dec_imm_type_out,
  output logic [31:0]      dec_imm_out,
  output logic             dec_illegal_out,
  output logic [CNT_W-1:0] decoded_count_out
);

  occ_state_t          state_q, state_d;
  dec_entry_t          head_q, head_d;
  dec_entry_t          skid_q, skid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ready_q, valid_q;
  logic [IMM_TYPE_W:0] cls;
  logic [31:0]         imm_ext;
  dec_entry_t          new_entry;
  logic                push, pop;

  assign cls = classify(instr_in[6:0]);

  sign_extender u_sign_extender (
    .instruction_in   (instr_in),
    .imm_type_in      (cls[IMM_TYPE_W-1:0]),
    .imm_extended_out (imm_ext)
  );

  assign new_entry = '{instr: instr_in, imm_type: cls[IMM_TYPE_W-1:0],
                       imm: imm_ext, illegal: cls[IMM_TYPE_W]};

  assign push = instr_valid_in & ready_q;
  assign pop  = valid_q & dec_ready_in;

  // Occupancy next-state, buffer moves and delivered-count update.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    if (flush_in) begin
      state_d = EMPTY;
    end else begin
      if (pop) cnt_d = cnt_q + CNT_W'(1);
      case (state_q)
        EMPTY: begin
          if (push) begin
            head_d  = new_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_d = new_entry;
          end else if (push) begin
            skid_d  = new_entry;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State, entries, counter and handshake flags.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d != FULL);
      valid_q <= (state_d != EMPTY);
    end
  end

  assign instr_ready_out   = ready_q;
  assign dec_valid_out     = valid_q;
  assign dec_instr_out     = head_q.instr;
  assign dec_imm_type_out  = head_q.imm_type;
  assign dec_imm_out       = head_q.imm;
  assign dec_illegal_out   = head_q.illegal;
  assign decoded_count_out = cnt_q;

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Directed scoreboard bench for imm_decode_ctrl.
module tb_imm_decode_ctrl;
  import sigma_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        instr_ready;
  logic        flush = 1'b0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instr;
  logic [2:0]  dec_imm_type;
  logic [31:0] dec_imm;
  logic        dec_illegal;
  logic [31:0] dec_count;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;
  logic [31:0] exp_cnt = 32'd0;
  dec_entry_t  sb[$];

  always #5 clk = ~clk;

  imm_decode_ctrl #(.CNT_W(32)) dut (
    .clk_in            (clk),
    .rst_n_in          (rst_n),
    .instr_valid_in    (instr_valid),
    .instr_in          (instr),
    .instr_ready_out   (instr_ready),
    .flush_in          (flush),
    .dec_valid_out     (dec_valid),
    .dec_ready_in      (dec_ready),
    .dec_instr_out     (dec_instr),
    .dec_imm_type_out  (dec_imm_type),
    .dec_imm_out       (dec_imm),
    .dec_illegal_out   (dec_illegal),
    .decoded_count_out (dec_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic dec_entry_t mk(input logic [31:0] ins, input logic [2:0] t,
                                    input logic [31:0] imm, input logic ill);
    dec_entry_t e;
    e.instr = ins; e.imm_type = t; e.imm = imm; e.illegal = ill;
    return e;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(instr_ready), 64'(1'b1));
    chk({tag, "_valid"}, 64'(dec_valid), 64'(1'b0));
    chk({tag, "_instr"}, 64'(dec_instr), 64'd0);
    chk({tag, "_type"}, 64'(dec_imm_type), 64'(IMM_TYPE_NONE));
    chk({tag, "_imm"}, 64'(dec_imm), 64'd0);
    chk({tag, "_ill"}, 64'(dec_illegal), 64'(1'b0));
    chk({tag, "_count"}, 64'(dec_count), 64'd0);
  endtask

  // One cycle starting at a falling edge: drive, check vs scoreboard, clock, check count.
  task automatic step(input logic v, input logic [31:0] ins, input dec_entry_t e,
                      input logic dr, input logic fl);
    logic acc, pop;
    instr_valid = v; instr = ins; dec_ready = dr; flush = fl;
    #1;
    chk("ready", 64'(instr_ready), 64'(sb.size() < 2));
    chk("valid", 64'(dec_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("head_instr", 64'(dec_instr), 64'(sb[0].instr));
      chk("head_type", 64'(dec_imm_type), 64'(sb[0].imm_type));
      chk("head_imm", 64'(dec_imm), 64'(sb[0].imm));
      chk("head_ill", 64'(dec_illegal), 64'(sb[0].illegal));
    end
    acc = v & instr_ready;
    pop = dec_valid & dr;
    if (fl) begin
      sb.delete();
    end else begin
      if (pop && sb.size() != 0) begin
        void'(sb.pop_front());
        exp_cnt = exp_cnt + 32'd1;
      end
      if (acc) sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    chk("count", 64'(dec_count), 64'(exp_cnt));
  endtask

  dec_entry_t e_addi, e_beq, e_lui, e_jal, e_bad, e_add, e_sw, e_neg, e_auipc, e_zero, z;

  initial begin
    z       = '0;
    e_addi  = mk(32'h00500093, IMM_TYPE_I, 32'h00000005, 1'b0);
    e_beq   = mk(32'hFE0006E3, IMM_TYPE_B, 32'hFFFFFFEC, 1'b0);
    e_lui   = mk(32'h123450B7, IMM_TYPE_U, 32'h12345000, 1'b0);
    e_jal   = mk(32'hC19FF06F, IMM_TYPE_J, 32'hFFFFFC18, 1'b0);
    e_bad   = mk(32'h12345678, IMM_TYPE_NONE, 32'h00000000, 1'b1);
    e_add   = mk(32'h00B50533, IMM_TYPE_NONE, 32'h00000000, 1'b0);
    e_sw    = mk(32'h00112623, IMM_TYPE_S, 32'h0000000C, 1'b0);
    e_neg   = mk(32'hFFF00093, IMM_TYPE_I, 32'hFFFFFFFF, 1'b0);
    e_auipc = mk(32'h00001517, IMM_TYPE_U, 32'h00001000, 1'b0);
    e_zero  = mk(32'h00000000, IMM_TYPE_NONE, 32'h00000000, 1'b1);

    // Reset state
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Single push, then pop
    step(1'b1, e_addi.instr, e_addi, 1'b0, 1'b0);
    step(1'b0, 32'd0, z, 1'b1, 1'b0);
    step(1'b0, 32'd0, z, 1'b1, 1'b0);

    // Streaming at full rate
    step(1'b1, e_beq.instr, e_beq, 1'b1, 1'b0);
    step(1'b1, e_lui.instr, e_lui, 1'b1, 1'b0);
    step(1'b1, e_jal.instr, e_jal, 1'b1, 1'b0);
    step(1'b1, e_sw.instr, e_sw, 1'b1, 1'b0);
    step(1'b0, 32'd0, z, 1'b1, 1'b0);

    // Back-pressure: three offered, two accepted, third accepted after first pop
    step(1'b1, e_neg.instr, e_neg, 1'b0, 1'b0);
    step(1'b1, e_auipc.instr, e_auipc, 1'b0, 1'b0);
    step(1'b1, e_add.instr, e_add, 1'b0, 1'b0);
    step(1'b1, e_add.instr, e_add, 1'b0, 1'b0);
    step(1'b1, e_add.instr, e_add, 1'b1, 1'b0);
    step(1'b1, e_add.instr, e_add, 1'b1, 1'b0);
    step(1'b0, 32'd0, z, 1'b1, 1'b0);
    step(1'b0, 32'd0, z, 1'b1, 1'b0);
    step(1'b0, 32'd0, z, 1'b1, 1'b0);

    // Illegal and legal NONE-type opcodes
    step(1'b1, e_bad.instr, e_bad, 1'b1, 1'b0);
    step(1'b1, e_add.instr, e_add, 1'b1, 1'b0);
    step(1'b1, e_zero.instr, e_zero, 1'b1, 1'b0);
    step(1'b0, 32'd0, z, 1'b1, 1'b0);

    // Flush while EMPTY is a no-op
    step(1'b0, 32'd0, z, 1'b0, 1'b1);
    step(1'b0, 32'd0, z, 1'b0, 1'b0);

    // Flush while FULL with concurrent push and pop
    step(1'b1, e_beq.instr, e_beq, 1'b0, 1'b0);
    step(1'b1, e_lui.instr, e_lui, 1'b0, 1'b0);
    step(1'b1, e_jal.instr, e_jal, 1'b1, 1'b1);
    step(1'b0, 32'd0, z, 1'b1, 1'b0);

    // Asynchronous reset while FULL
    step(1'b1, e_sw.instr, e_sw, 1'b0, 1'b0);
    step(1'b1, e_neg.instr, e_neg, 1'b0, 1'b0);
    chk("full_ready", 64'(instr_ready), 64'(1'b0));
    instr_valid = 1'b0; dec_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    sb.delete();
    exp_cnt = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // First push after reset delivered normally
    step(1'b1, e_auipc.instr, e_auipc, 1'b0, 1'b0);
    step(1'b0, 32'd0, z, 1'b1, 1'b0);
    step(1'b0, 32'd0, z, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imm_decode_ctrl.md
# imm_decode_ctrl

Immediate-decode stage controller for the SigmaCore decode path. It accepts 32-bit instructions over a valid/ready handshake and derives the immediate format from the opcode. It drives the `sign_extender` with that format and buffers the result in a two-entry skid buffer, so downstream back-pressure never drops or duplicates an instruction. It sits between the fetch output register and the execute-stage operand mux, and it also counts decoded instructions for performance monitoring.

## Interface
Parameters:
- `CNT_W`, default 32: width of the decoded-instruction counter.

Ports:
- `clk_in`  input  1  single clock; all state updates on its rising edge.
- `rst_n_in`  input  1  asynchronous, active-low reset.
- `instr_valid_in`  input  1  upstream presents `instr_in`.
- `instr_in`  input  32  raw RV32I instruction.
- `instr_ready_out`  output  1  stage can accept this cycle.
- `flush_in`  input  1  discard all buffered entries (branch redirect).
- `dec_valid_out`  output  1  head entry valid.
- `dec_ready_in`  input  1  downstream accepts head entry.
- `dec_instr_out`  output  32  instruction of head entry.
- `dec_imm_type_out`  output  3  `IMM_TYPE_*` code of head entry.
- `dec_imm_out`  output  32  extended immediate of head entry.
- `dec_illegal_out`  output  1  head entry has an unrecognised opcode.
- `decoded_count_out`  output  CNT_W  number of entries delivered downstream.

## Operation
Opcode map (`instr_in[6:0]`):
- I-type: 0000011, 0001111, 0010011, 1100111, 1110011.
- S-type: 0100011. B-type: 1100011. U-type: 0110111, 0010111. J-type: 1101111.
- NONE: 0110011, legal and immediate 0.
- Any other opcode, including `[1:0] != 2'b11`: NONE with `illegal = 1`.

Datapath and buffer:
- Classification and extension are combinational on `instr_in`. The result tuple {instr, imm_type, imm, illegal} is captured on accept, where accept = `instr_valid_in & instr_ready_out`.
- Occupancy FSM with states `EMPTY`, `ONE`, `FULL`. Let push = accept and pop = `dec_valid_out & dec_ready_in`.
  - EMPTY: push goes to ONE.
  - ONE: push without pop goes to FULL; pop without push goes to EMPTY; push with pop stays in ONE, and the head is replaced by the new entry.
  - FULL: pop goes to ONE, and the skid entry moves to the head. Push cannot occur because ready is low.
- `instr_ready_out = (state != FULL)`, decoded from the registered state only. There is no combinational path from `dec_ready_in`.
- `dec_valid_out = (state != EMPTY)`. The head outputs hold stable while valid is high and ready is low.
- Flush has priority over push and pop in the same cycle. The next state is EMPTY, any concurrent push is discarded, and the counter does not increment for a concurrent pop.
- `decoded_count_out` increments by 1 on each non-flushed pop and wraps modulo 2^CNT_W.

## Timing
Reset values and latency:
- Reset (async assert, sync release) forces state EMPTY, `instr_ready_out = 1`, `dec_valid_out = 0`, `dec_instr_out = 0`, `dec_imm_type_out = IMM_TYPE_NONE`, `dec_imm_out = 0`, `dec_illegal_out = 0`, and `decoded_count_out = 0`.
- Latency is 1 cycle: an instruction accepted at edge N is valid on the head outputs after edge N.
- Throughput is one instruction per cycle while `dec_ready_in` stays high.

Back-pressure:
- With `dec_ready_in` low, at most 2 entries are accepted.
- `instr_ready_out` falls in the cycle after the second accept.
- It rises in the cycle after the first pop.

Reset and flush corner cases:
- Reset asserted mid-transfer drops all entries immediately, without waiting for a clock edge.
- Flush in state EMPTY is a no-op.

## Structure
- `sigma_pkg` holds the opcode localparams (`OPC_LOAD`, `OPC_STORE`, `OPC_BRANCH`, and so on), the existing `IMM_TYPE_*` codes, and a `dec_entry_t` packed struct {instr, imm_type, imm, illegal}.
- One `sign_extender` instance, with `instruction_in` fed by `instr_in`, `imm_type_in` fed by the mapped type, and `imm_extended_out` feeding the entry.
- Buffer entries are two `dec_entry_t` registers: head and skid.

## Test plan
- Reset, then a single push of 0x00500093 → one cycle later `dec_valid_out = 1`, type I, imm 0x00000005, illegal 0, count 1 after pop.
- Stream 0xFE0006E3, 0x123450B7, 0xC19FF06F with `dec_ready_in` high → one per cycle, outputs in order: B/0xFFFFFFEC, U/0x12345000, J/0xFFFFFC18.
- Hold `dec_ready_in` low and offer 3 instructions → 2 accepted and `instr_ready_out = 0`. Release ready → all 3 delivered in order, with no duplicates.
- Push 0x12345678 → NONE, imm 0, `dec_illegal_out = 1`. Push 0x00B50533 → NONE, illegal 0.
- FULL state plus `flush_in` together with `instr_valid_in` and `dec_ready_in` high → next cycle EMPTY, no entry delivered, count unchanged.
- Assert `rst_n_in` low mid-cycle while FULL → outputs go to reset values immediately. After release, the first push is delivered normally.
